// File: rtl/loop_filter_pi_gear_if.sv
// rtl/loop_filter_pi_gear_if.sv - phase-sample in / control-word out bundle for the PI loop filter
interface loop_filter_pi_gear_if #(
  parameter int OUT_W = 20
);
  logic             pd_valid;
  logic             pd_early;
  logic             freeze;
  logic [OUT_W-1:0] ctrl_out;
  logic             ctrl_valid;
  logic             locked;

  modport master (
    output pd_valid, pd_early, freeze,
    input  ctrl_out, ctrl_valid, locked
  );

  modport slave (
    input  pd_valid, pd_early, freeze,
    output ctrl_out, ctrl_valid, locked
  );
endinterface

// File: rtl/loop_filter_pi_gear.sv
// rtl/loop_filter_pi_gear.sv - gear-shifting bang-bang PI loop filter with lock detector
module loop_filter_pi_gear #(
  parameter int OUT_W      = 20,
  parameter int INIT_WORD  = 2 ** (OUT_W - 1),
  parameter int KP_ACQ     = 500,
  parameter int KI_ACQ     = 100,
  parameter int KP_TRK     = 125,
  parameter int KI_TRK     = 25,
  parameter int LOCK_CNT   = 64,
  parameter int UNLOCK_RUN = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  loop_filter_pi_gear_if.slave bus
);

  typedef enum logic {ACQ = 1'b0, TRACK = 1'b1} state_t;

  localparam logic [OUT_W-1:0] INIT_V   = OUT_W'(INIT_WORD);
  localparam logic [7:0]       LOCK_V   = 8'(LOCK_CNT);
  localparam logic [7:0]       UNLOCK_V = 8'(UNLOCK_RUN);

  state_t           state;
  logic [OUT_W-1:0] integ;
  logic [OUT_W-1:0] ctrl_q;
  logic             valid_q;
  logic             locked_q;
  logic [7:0]       alt_cnt;
  logic [7:0]       run_cnt;
  logic             prev_valid;
  logic             prev_sign;

  logic             accept;
  logic [OUT_W-1:0] kp;
  logic [OUT_W-1:0] ki;
  logic [OUT_W:0]   integ_up;
  logic [OUT_W-1:0] integ_n;
  logic [OUT_W:0]   ctrl_up;
  logic [OUT_W-1:0] ctrl_n;
  logic [7:0]       alt_inc;
  logic [7:0]       run_inc;

  always_comb begin
    accept   = bus.pd_valid & ~bus.freeze;
    kp       = (state == ACQ) ? OUT_W'(KP_ACQ) : OUT_W'(KP_TRK);
    ki       = (state == ACQ) ? OUT_W'(KI_ACQ) : OUT_W'(KI_TRK);
    // One extra bit on the sums exposes overflow so the clamp can catch it.
    integ_up = {1'b0, integ} + {1'b0, ki};
    if (bus.pd_early) begin
      integ_n = integ_up[OUT_W] ? '1 : integ_up[OUT_W-1:0];
    end else begin
      integ_n = (integ >= ki) ? (integ - ki) : '0;
    end
    ctrl_up = {1'b0, integ_n} + {1'b0, kp};
    if (bus.pd_early) begin
      ctrl_n = ctrl_up[OUT_W] ? '1 : ctrl_up[OUT_W-1:0];
    end else begin
      ctrl_n = (integ_n >= kp) ? (integ_n - kp) : '0;
    end
    alt_inc = (alt_cnt == 8'hFF) ? alt_cnt : alt_cnt + 8'd1;
    run_inc = (run_cnt == 8'hFF) ? run_cnt : run_cnt + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ACQ;
      integ      <= INIT_V;
      ctrl_q     <= INIT_V;
      valid_q    <= 1'b0;
      locked_q   <= 1'b0;
      alt_cnt    <= 8'd0;
      run_cnt    <= 8'd0;
      prev_valid <= 1'b0;
      prev_sign  <= 1'b0;
    end else begin
      valid_q <= accept;
      if (accept) begin
        integ      <= integ_n;
        ctrl_q     <= ctrl_n;
        prev_valid <= 1'b1;
        prev_sign  <= bus.pd_early;
        if (prev_valid) begin
          if (bus.pd_early != prev_sign) begin
            alt_cnt <= alt_inc;
            run_cnt <= 8'd0;
            if (state == ACQ && alt_inc == LOCK_V) begin
              state    <= TRACK;
              locked_q <= 1'b1;
            end
          end else begin
            run_cnt <= run_inc;
            alt_cnt <= 8'd0;
            if (state == TRACK && run_inc == UNLOCK_V) begin
              state    <= ACQ;
              locked_q <= 1'b0;
            end
          end
        end
      end
    end
  end

  assign bus.ctrl_out   = ctrl_q;
  assign bus.ctrl_valid = valid_q;
  assign bus.locked     = locked_q;

endmodule

// File: tb/tb_loop_filter_pi_gear.sv
// tb/tb_loop_filter_pi_gear.sv - self-checking bench for loop_filter_pi_gear
module tb_loop_filter_pi_gear;

  localparam int  OUT_W  = 20;
  localparam longint MAXV = (longint'(1) << OUT_W) - 1;
  localparam longint INIT = longint'(1) << (OUT_W - 1);

  logic clk;
  logic rst_n;
  loop_filter_pi_gear_if #(.OUT_W(OUT_W)) bus ();

  loop_filter_pi_gear #(.OUT_W(OUT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: plain integers and streak lengths.
  longint m_integ, m_ctrl;
  bit     m_valid, m_locked, m_have_prev, m_prev_sign;
  int     m_alt_streak, m_rep_streak;

  function automatic longint clamp(input longint x);
    if (x < 0) return 0;
    if (x > MAXV) return MAXV;
    return x;
  endfunction

  function automatic void model_reset();
    m_integ = INIT; m_ctrl = INIT; m_valid = 0; m_locked = 0;
    m_have_prev = 0; m_prev_sign = 0; m_alt_streak = 0; m_rep_streak = 0;
  endfunction

  function automatic void model_step(input bit r, input bit v, input bit e, input bit f);
    longint kp, ki;
    if (!r) begin
      model_reset();
      return;
    end
    m_valid = v && !f;
    if (!m_valid) return;
    kp = m_locked ? 125 : 500;
    ki = m_locked ? 25 : 100;
    m_integ = clamp(e ? m_integ + ki : m_integ - ki);
    m_ctrl  = clamp(e ? m_integ + kp : m_integ - kp);
    if (m_have_prev) begin
      if (e != m_prev_sign) begin
        m_alt_streak++;
        m_rep_streak = 0;
        if (!m_locked && m_alt_streak == 64) m_locked = 1;
      end else begin
        m_rep_streak++;
        m_alt_streak = 0;
        if (m_locked && m_rep_streak == 16) m_locked = 0;
      end
    end
    m_have_prev = 1;
    m_prev_sign = e;
  endfunction

  task automatic check(input string name, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      if (n_errors <= 40)
        $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit v, input bit e, input bit f);
    rst_n = r; bus.pd_valid = v; bus.pd_early = e; bus.freeze = f;
    @(posedge clk);
    model_step(r, v, e, f);
    #1;
    check("model_ctrl_out", longint'(bus.ctrl_out), m_ctrl);
    check("model_ctrl_valid", longint'(bus.ctrl_valid), longint'(m_valid));
    check("model_locked", longint'(bus.locked), longint'(m_locked));
  endtask

  typedef struct {
    bit     r, v, e, f;
    longint exp_ctrl;
    bit     exp_valid, exp_locked;
  } vec_t;

  vec_t vecs[$];

  task automatic lock_from_reset();
    step(0, 1, 0, 0);
    for (int i = 1; i <= 65; i++) begin
      step(1, 1, (i % 2) == 1, 0);
      if (i == 64) check("not_locked_at_64", longint'(bus.locked), 0);
    end
    check("locked_at_65", longint'(bus.locked), 1);
  endtask

  initial begin
    rst_n = 0; bus.pd_valid = 0; bus.pd_early = 0; bus.freeze = 0;
    model_reset();

    vecs.push_back('{0, 1, 1, 0, 524288, 0, 0});
    vecs.push_back('{0, 1, 1, 0, 524288, 0, 0});
    vecs.push_back('{1, 1, 1, 0, 524888, 1, 0});
    vecs.push_back('{1, 0, 1, 0, 524888, 0, 0});
    vecs.push_back('{0, 0, 0, 0, 524288, 0, 0});
    vecs.push_back('{1, 1, 0, 0, 523688, 1, 0});
    for (int i = 0; i < 5; i++) vecs.push_back('{1, 0, 0, 0, 523688, 0, 0});
    vecs.push_back('{1, 1, 1, 1, 523688, 0, 0});
    foreach (vecs[i]) begin
      step(vecs[i].r, vecs[i].v, vecs[i].e, vecs[i].f);
      check($sformatf("vec%0d_ctrl", i), longint'(bus.ctrl_out), vecs[i].exp_ctrl);
      check($sformatf("vec%0d_valid", i), longint'(bus.ctrl_valid), longint'(vecs[i].exp_valid));
      check($sformatf("vec%0d_locked", i), longint'(bus.locked), longint'(vecs[i].exp_locked));
    end

    // Saturation high, then one late step off the rail
    step(0, 0, 0, 0);
    for (int i = 0; i < 6000; i++) step(1, 1, 1, 0);
    check("sat_high", longint'(bus.ctrl_out), 1048575);
    step(1, 1, 0, 0);
    check("sat_high_late", longint'(bus.ctrl_out), 1047975);

    // Saturation low, then one early step off the floor
    step(0, 0, 0, 0);
    for (int i = 0; i < 6000; i++) step(1, 1, 0, 0);
    check("sat_low", longint'(bus.ctrl_out), 0);
    step(1, 1, 1, 0);
    check("sat_low_early", longint'(bus.ctrl_out), 600);

    // Lock, tracking gains, unlock, acquisition gains again
    lock_from_reset();
    check("lock_ctrl", longint'(bus.ctrl_out), 524888);
    step(1, 1, 1, 0);
    check("trk_early_ctrl", longint'(bus.ctrl_out), 524538);
    for (int i = 1; i <= 17; i++) begin
      step(1, 1, 0, 0);
      if (i == 16) check("still_locked_16", longint'(bus.locked), 1);
    end
    check("unlocked_17", longint'(bus.locked), 0);
    check("trk_late_ctrl", longint'(bus.ctrl_out), 523863);
    step(1, 1, 0, 0);
    check("acq_again_ctrl", longint'(bus.ctrl_out), 523388);

    // Freeze mid-lock: nothing moves, counters resume where they were
    lock_from_reset();
    for (int i = 0; i < 10; i++) begin
      step(1, $urandom_range(0, 1), $urandom_range(0, 1), 1);
      check("frz_ctrl", longint'(bus.ctrl_out), 524888);
      check("frz_valid", longint'(bus.ctrl_valid), 0);
      check("frz_locked", longint'(bus.locked), 1);
    end
    for (int i = 1; i <= 16; i++) begin
      step(1, 1, 1, 0);
      if (i == 15) check("frz_run_15", longint'(bus.locked), 1);
    end
    check("frz_run_16", longint'(bus.locked), 0);

    // Reset in TRACK wins over a coincident sample
    lock_from_reset();
    step(0, 1, 1, 0);
    check("rst_mid_ctrl", longint'(bus.ctrl_out), 524288);
    check("rst_mid_valid", longint'(bus.ctrl_valid), 0);
    check("rst_mid_locked", longint'(bus.locked), 0);

    // Randomised run with alternating and repeating bursts
    begin
      bit alt_mode = 1;
      bit last_e = 0;
      bit e, v, f, r;
      for (int i = 0; i < 4000; i++) begin
        if ($urandom_range(0, 99) < 2) alt_mode = ~alt_mode;
        r = ($urandom_range(0, 999) != 0);
        v = ($urandom_range(0, 9) < 8);
        f = ($urandom_range(0, 19) == 0);
        e = alt_mode ? ~last_e : (($urandom_range(0, 9) < 9) ? last_e : ~last_e);
        if (v && !f) last_e = e;
        step(r, v, e, f);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
